// File: rtl/smallcalc_pkg.sv
// Shared constants and types for the small-calculator operand sequencer.
package smallcalc_pkg;

  // Default operand/result width; must match the downstream ALU.
  localparam int SC_W = 5;

  // ALU opcodes as presented on the opcode switches.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  // Sequencer states; the encoding is shown directly on the LEDs.
  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_EXEC    = 2'b10,
    ST_SHOW    = 2'b11
  } state_e;

endpackage

// File: rtl/smallcalc_if.sv
// Board-side and ALU-side signals of the calculator sequencer, bundled.
// master: the sequencer; slave: the board switches/buttons, ALU and display.
interface smallcalc_if #(
  parameter int W = 5
) ();
  logic [W-1:0] sw_data;
  logic [1:0]   sw_op;
  logic         btn_enter;
  logic         btn_clear;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [1:0]   alu_c;
  logic [W-1:0] alu_out;
  logic [W-1:0] result;
  logic         flag;
  logic         result_valid;
  logic [1:0]   state_o;

  modport master (
    input  sw_data, sw_op, btn_enter, btn_clear, alu_out,
    output alu_in1, alu_in2, alu_c, result, flag, result_valid, state_o
  );

  modport slave (
    output sw_data, sw_op, btn_enter, btn_clear, alu_out,
    input  alu_in1, alu_in2, alu_c, result, flag, result_valid, state_o
  );
endinterface

// File: rtl/smallcalc_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press. Releases are debounced silently.
module smallcalc_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int            CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Count consecutive samples that disagree with the accepted level; accept
  // the new level on the DB_CYCLES-th one and flag it if it is a press.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      level_d = sync2_q;
      cnt_d   = '0;
      pulse_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The accepted level resets to "pressed" so a button held through reset
  // must first be seen released before a press can be reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/smallcalc_ctrl.sv
// Operand-entry sequencer in front of the small-calculator ALU.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ENTER_A 00 | waiting for enter; captures operand A from the switches
//   ENTER_B 01 | waiting for enter; captures operand B and the opcode
//   EXEC    10 | one cycle; registers the ALU result and carry/borrow flag
//   SHOW    11 | result on display; enter chains the result into operand A
//
// A clear press returns to ENTER_A with every register zeroed and wins over
// an enter press in the same cycle. Enter presses arriving in EXEC are dropped.
module smallcalc_ctrl
  import smallcalc_pkg::*;
#(
  parameter int W         = SC_W,
  parameter int DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  smallcalc_if.master bus
);

  logic enter_pulse;
  logic clear_pulse;

  smallcalc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_enter),
    .pulse   (enter_pulse)
  );

  smallcalc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_clear),
    .pulse   (clear_pulse)
  );

  state_e       state_q, state_d;
  logic [W-1:0] alu_in1_q, alu_in1_d;
  logic [W-1:0] alu_in2_q, alu_in2_d;
  op_e          alu_c_q, alu_c_d;
  logic [W-1:0] result_q, result_d;
  logic         flag_q, flag_d;
  logic         result_valid_q, result_valid_d;
  logic [W:0]   sum_ext;

  // Carry for add, unsigned borrow for sub; logic ops never flag.
  assign sum_ext = {1'b0, alu_in1_q} + {1'b0, alu_in2_q};

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d        = state_q;
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    alu_c_d        = alu_c_q;
    result_d       = result_q;
    flag_d         = flag_q;
    result_valid_d = result_valid_q;
    if (clear_pulse) begin
      state_d        = ST_ENTER_A;
      alu_in1_d      = '0;
      alu_in2_d      = '0;
      alu_c_d        = OP_ADD;
      result_d       = '0;
      flag_d         = 1'b0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (enter_pulse) begin
            alu_in1_d = bus.sw_data;
            state_d   = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (enter_pulse) begin
            alu_in2_d = bus.sw_data;
            alu_c_d   = op_e'(bus.sw_op);
            state_d   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_d = bus.alu_out;
          case (alu_c_q)
            OP_ADD:  flag_d = sum_ext[W];
            OP_SUB:  flag_d = (alu_in1_q < alu_in2_q);
            default: flag_d = 1'b0;
          endcase
          result_valid_d = 1'b1;
          state_d        = ST_SHOW;
        end
        ST_SHOW: begin
          if (enter_pulse) begin
            alu_in1_d      = result_q;
            result_valid_d = 1'b0;
            state_d        = ST_ENTER_B;
          end
        end
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ENTER_A;
      alu_in1_q      <= '0;
      alu_in2_q      <= '0;
      alu_c_q        <= OP_ADD;
      result_q       <= '0;
      flag_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      alu_c_q        <= alu_c_d;
      result_q       <= result_d;
      flag_q         <= flag_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.alu_in1      = alu_in1_q;
  assign bus.alu_in2      = alu_in2_q;
  assign bus.alu_c        = alu_c_q;
  assign bus.result       = result_q;
  assign bus.flag         = flag_q;
  assign bus.result_valid = result_valid_q;
  assign bus.state_o      = state_q;

endmodule

// File: doc/smallcalc_ctrl.md
# smallcalc_ctrl

Operand-entry and sequencing stage that sits directly upstream of the small-calculator ALU (5-bit operands, 2-bit opcode). It debounces the enter/clear push-buttons, steps through operand A / operand B + opcode entry from the board switches, drives the ALU inputs, and registers the ALU output together with a carry/borrow flag for display. Results can be chained: the last result becomes the next operand A.

## Interface
- `W`, 5: operand/result width; must match the ALU width.
- `DB_CYCLES`, 4: number of consecutive stable synchronized samples (≥1) before a button level change is accepted.
- `clk` input 1: single system clock.
- `rst_n` input 1: reset, **asynchronous, active-low**.
- `sw_data` input W: operand switches; asynchronous to `clk`, sampled only on an accepted enter press.
- `sw_op` input 2: opcode switches; 00 add, 01 sub, 10 and, 11 xor.
- `btn_enter` input 1: raw enter button, active-high, may bounce.
- `btn_clear` input 1: raw clear button, active-high, may bounce.
- `alu_in1` output W: operand A register, wired to the ALU's first operand.
- `alu_in2` output W: operand B register, wired to the ALU's second operand.
- `alu_c` output 2: opcode register, wired to the ALU opcode.
- `alu_out` input W: combinational ALU result.
- `result` output W: registered result.
- `flag` output 1: add carry-out / sub borrow; 0 for and/xor.
- `result_valid` output 1: high while in SHOW.
- `state_o` output 2: current state code for LEDs.

## Operation
- Each button: 2-flop synchronizer → debounce counter → 1-cycle `*_pulse` on accepted 0→1 transition. Releases are debounced too but produce no pulse.
- States (`state_o`): ENTER_A=00, ENTER_B=01, EXEC=10, SHOW=11.
- ENTER_A + enter_pulse: `alu_in1`←`sw_data`, go ENTER_B.
- ENTER_B + enter_pulse: `alu_in2`←`sw_data`, `alu_c`←`sw_op`, go EXEC.
- EXEC (exactly 1 cycle, unconditional): `result`←`alu_out`; `flag`←carry of `alu_in1`+`alu_in2` (bit W of the W+1-bit sum) for 00, (`alu_in1`<`alu_in2`, unsigned) for 01, else 0; go SHOW.
- SHOW + enter_pulse: chain — `alu_in1`←`result`, go ENTER_B; `result`/`flag` hold, `result_valid` drops.
- clear_pulse in any state: all registers←0, go ENTER_A. Clear has priority over a same-cycle enter_pulse.
- enter_pulse in EXEC is ignored (it is consumed, not queued).
- Arithmetic is modulo 2^W; the block never alters `alu_out`.

## Timing
- Reset (async assert, sync-style deassert through `clk`): state ENTER_A, `alu_in1`/`alu_in2`/`result`=0, `alu_c`=00, `flag`=0, `result_valid`=0, `state_o`=00, synchronizers and debounce counters 0.
- Button latency: a clean rising edge at the pin yields a pulse 2 (sync) + DB_CYCLES cycles later; a glitch shorter than DB_CYCLES synchronized cycles yields no pulse.
- A state update takes effect on the edge ending the pulse cycle; `alu_*` change on that same edge.
- ENTER_B→EXEC→SHOW: `result`/`flag` valid and `result_valid`=1 two edges after the enter pulse.
- Reset mid-operation: all state is discarded immediately; a held button after reset release must go low and high again (debounced) before it can generate a pulse.

## Structure
- `smallcalc_pkg`: opcode constants (OP_ADD, OP_SUB, OP_AND, OP_XOR), state enum/encoding, default W.
- Sub-module `smallcalc_debounce` (synchronizer + counter + rising-edge pulse, parameter DB_CYCLES), instantiated twice.
- ALU instantiated outside this block, at the calculator top level.

## Test plan
- W=5, DB=4: A=20, B=15, op=00 → SHOW with `result`=3, `flag`=1, `result_valid`=1 two cycles after the B pulse.
- A=3, B=7, op=01 → `result`=28, `flag`=1; A=22, B=13, op=10 → `result`=4, `flag`=0.
- Chain: from `result`=3, press enter → ENTER_B with `alu_in1`=3; B=4, op=11 → `result`=7, `flag`=0.
- Enter bounce of 2-cycle high pulses ×3, then low → no state change; hold 6 cycles → exactly one pulse, one transition.
- Clear and enter accepted in the same cycle while in ENTER_B → ENTER_A, all registers 0.
- Assert `rst_n`=0 in SHOW (mid-cycle) → outputs immediately at reset values; `btn_enter` held through release → no pulse until re-pressed.
